fixed_point_inv_sqrt: RTL
=========================

// Module: fixed_point_inv_sqrt
// PURPOSE
//  Iterative signed fixed-point reciprocal square root, y = 1/sqrt(x).
//  Companion stage to the fixed-point ALU: the ALU reserves its 3'b010 op
//  for this unit, which consumes ALU/register operands and returns a result.
//  Guess from MSB position, then NR_ITERS Newton-Raphson steps on one shared
//  multiplier. Used for ray-direction normalisation.
// PARAMETERS
//  WIDTH      32  total signed word width (matches `WIDTH)
//  FRAC_BITS  16  fractional bits of the Q format
//  NR_ITERS   4   Newton-Raphson iterations, 1..15
// PORTS
//  clk_in     in   1      system clock, all state on rising edge
//  rst_in     in   1      reset, asynchronous, active-high
//  x_in       in   WIDTH  signed operand x
//  valid_in   in   1      x_in valid
//  ready_out  out  1      unit idle; accepts x_in this cycle
//  res_out    out  WIDTH  signed result 1/sqrt(x)
//  err_out    out  1      x_in was <= 0; res_out saturated
//  valid_out  out  1      res_out/err_out valid
//  ready_in   in   1      downstream accepts result
// BEHAVIOUR
//  Reset (async, rst_in=1): state=IDLE, res_out=0, err_out=0, valid_out=0,
//   iteration counter=0, internal regs=0. ready_out=(state==IDLE), so 1 in reset.
//   Asserting rst_in mid-operation abandons the operation. No result is emitted.
//  FSM: IDLE, INIT, SQ, MX, SUB, UPD, DONE.
//   IDLE: ready_out=1. On valid_in: latch x. If x<=0, go to DONE with
//    res=2^(WIDTH-1)-1 and err=1. Otherwise go to INIT with err=0.
//   INIT: p = index of MSB of x; e = p-FRAC_BITS; s = FRAC_BITS-ceil(e/2),
//    with ceil toward +inf for negative e. Clamp s to [0,WIDTH-2]. y=1<<s.
//    Clear the counter, then go to SQ.
//   SQ:  t = mul(x,y)                 -> MX
//   MX:  t = mul(t,y)                 -> SUB
//   SUB: t = (3<<(FRAC_BITS-1)) - (t>>>1); clamp t<0 to 0  -> UPD
//   UPD: y = mul(y,t); count++. If count==NR_ITERS, res=y and go to DONE.
//    Otherwise go to SQ.
//   DONE: valid_out=1. res_out/err_out held stable until ready_in.
//    valid_out&&ready_in -> IDLE, valid_out falls next cycle.
//  mul(a,b): full 2*WIDTH signed product, arithmetic >>> FRAC_BITS.
//   Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//  Operation order x*y then *y avoids y^2 overflow for small x.
//  Latency, accept edge to valid_out rising:
//   positive x: 4*NR_ITERS+2 cycles (18 at default).
//   x<=0: 1 cycle.
//  Throughput: one op per (latency+1) cycles minimum. No accept while busy or
//   in DONE. valid_in is ignored unless ready_out=1.
//  res_out/err_out update only on DONE entry. Between ops they keep their last
//   value and are undefined for use unless valid_out=1.
//  Accuracy (Q16.16, x in [2^-16, 2^15)): within 4 LSB of ideal for x>=0.25.
//   Below 0.25, truncation in x*y bounds accuracy.
// TESTING
//  x=0x00010000 (1.0) -> res 0x00010000 +-4 LSB, err=0, valid_out 18 cyc after accept
//  x=0x00040000 (4.0) -> 0x00008000 +-4; x=0x00004000 (0.25) -> 0x00020000 +-4
//  x=0x00000001 (2^-16) -> exactly 0x01000000 (256.0); x=0x00020000 -> 0x0000B505 +-4
//  x=0 and x=0xFFFF0000 (-1.0) -> res 0x7FFFFFFF, err=1, valid_out 1 cyc after accept
//  ready_in=0 for 6 cyc in DONE -> valid_out/res_out stable, ready_out=0, valid_in ignored
//  rst_in pulsed in SUB of iter 2 -> outputs 0 at once, ready_out=1; next op x=4.0 correct

Source files
------------

// File: rtl/fixed_point_inv_sqrt.sv
// ============================================================================
// Module   : fixed_point_inv_sqrt
// Brief    : Iterative signed fixed-point reciprocal square root, y = 1/sqrt(x)
// Revision : 1.0
// ============================================================================
`default_nettype none

module fixed_point_inv_sqrt #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16,
    parameter int NR_ITERS  = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] res_out,
    output logic             err_out,
    output logic             valid_out,
    input  logic             ready_in
);

    localparam int               C_SHW        = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] C_MAX        = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_MIN        = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_THREE_HALF = WIDTH'(3) << (FRAC_BITS - 1);
    localparam logic [3:0]       C_ITERS      = 4'(NR_ITERS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_SQ   = 3'd2;
    localparam logic [2:0] S_MX   = 3'd3;
    localparam logic [2:0] S_SUB  = 3'd4;
    localparam logic [2:0] S_UPD  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, t_q, t_d, res_q, res_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             err_q, err_d, valid_q, valid_d;

    logic signed [WIDTH-1:0]   w_ma, w_mb;
    logic signed [2*WIDTH-1:0] w_prod, w_shr;
    logic [WIDTH:0]            w_hi;
    logic [WIDTH-1:0]          w_mul;
    logic signed [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]          w_t_sub;
    int                        w_msb, w_e, w_half, w_s;
    logic [C_SHW-1:0]          w_shift;

    // Single shared multiplier; operand pair selected by the current step.
    always_comb begin
        w_ma = y_q;
        w_mb = t_q;
        case (state_q)
            S_SQ:    begin w_ma = x_q; w_mb = y_q; end
            S_MX:    begin w_ma = t_q; w_mb = y_q; end
            default: begin w_ma = y_q; w_mb = t_q; end
        endcase
        w_prod = (2*WIDTH)'(w_ma) * (2*WIDTH)'(w_mb);
        w_shr  = w_prod >>> FRAC_BITS;
        w_hi   = w_shr[2*WIDTH-1:WIDTH-1];
        if ((&w_hi) || !(|w_hi)) w_mul = w_shr[WIDTH-1:0];
        else                     w_mul = w_shr[2*WIDTH-1] ? C_MIN : C_MAX;

        w_sub = $signed({1'b0, C_THREE_HALF})
              - $signed({t_q[WIDTH-1], t_q[WIDTH-1], t_q[WIDTH-1:1]});
        if (w_sub[WIDTH])        w_t_sub = '0;
        else if (w_sub[WIDTH-1]) w_t_sub = C_MAX;
        else                     w_t_sub = w_sub[WIDTH-1:0];
    end

    // Initial guess: 2^-ceil(e/2) in Q format, (e+1)>>>1 is ceil(e/2) for any sign.
    always_comb begin
        w_msb = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x_q[i]) w_msb = i;
        end
        w_e    = w_msb - FRAC_BITS;
        w_half = (w_e + 1) >>> 1;
        w_s    = FRAC_BITS - w_half;
        if (w_s < 0)         w_s = 0;
        if (w_s > WIDTH - 2) w_s = WIDTH - 2;
        w_shift = w_s[C_SHW-1:0];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            t_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            t_q     <= t_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        t_d     = t_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    x_d = x_in;
                    if ($signed(x_in) <= 0) begin
                        res_d   = C_MAX;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: begin
                y_d     = C_ONE << w_shift;
                cnt_d   = '0;
                state_d = S_SQ;
            end
            S_SQ: begin
                t_d     = w_mul;
                state_d = S_MX;
            end
            S_MX: begin
                t_d     = w_mul;
                state_d = S_SUB;
            end
            S_SUB: begin
                t_d     = w_t_sub;
                state_d = S_UPD;
            end
            S_UPD: begin
                y_d   = w_mul;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q + 4'd1 == C_ITERS) begin
                    res_d   = w_mul;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SQ;
                end
            end
            S_DONE: begin
                if (ready_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_DONE);
    end

    always_comb begin
        ready_out = (state_q == S_IDLE);
        res_out   = res_q;
        err_out   = err_q;
        valid_out = valid_q;
    end

endmodule

`default_nettype wire
